// File: rtl/lbp_stream.sv
// lbp_stream: streaming 3x3 local-binary-pattern engine.
// The gray image is read once in raster order, one pixel per cycle. Two line
// buffers and a 3x3 window produce one LBP code per pixel slot. A write
// strobe carries each code to the result memory.
// Optional build macro LBP_BORDER_ZERO_EN: border pixels are also written,
// with code 0x00, so that every address 0..N-1 is written once.
//
// state | meaning
// IDLE  | waiting for gray_ready
// READ  | streaming read addresses 0..N-1, one per cycle
// DRAIN | reads finished, pipeline emits the remaining output slots
// DONE  | frame complete, finish held until reset
module lbp_stream #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14,
    parameter int THRESH = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [PIX_W-1:0]  gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);

    localparam int N     = IMG_W * IMG_H;
    localparam int CW    = $clog2(N + IMG_W + 3) + 1;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int PW1   = PIX_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N - 1);
    // Cycle (counted from the first READ cycle) whose sample completes the
    // window for pixel 0, and the cycle after the final output slot.
    localparam logic [CW-1:0]     EMIT_FIRST = CW'(IMG_W + 2);
    localparam logic [CW-1:0]     FRAME_END  = CW'(N + IMG_W + 2);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [PIX_W:0]    THR        = PW1'(THRESH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

    state_e              state_q, state_d;
    logic                gray_req_q, gray_req_d;
    logic [ADDR_W-1:0]   gray_addr_q, gray_addr_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [COL_W-1:0]    wp_q, wp_d;
    logic [COL_W-1:0]    o_col_q, o_col_d;
    logic [ROW_W-1:0]    o_row_q, o_row_d;
    logic [ADDR_W-1:0]   o_idx_q, o_idx_d;
    logic                lbp_valid_q, lbp_valid_d;
    logic [ADDR_W-1:0]   lbp_addr_q, lbp_addr_d;
    logic [7:0]          lbp_data_q, lbp_data_d;
    logic                finish_q, finish_d;

    // Window indexed [row][col]: row 0 is the oldest line, col 2 the newest pixel.
    logic [PIX_W-1:0]    win_q  [3][3];
    logic [PIX_W-1:0]    win_d  [3][3];
    logic [PIX_W-1:0]    win_sh [3][3];

    logic [PIX_W-1:0]    lb0_q [IMG_W];
    logic [PIX_W-1:0]    lb1_q [IMG_W];
    logic [PIX_W-1:0]    lb0_rd, lb1_rd;

    logic                shift_en;
    logic                interior;
    logic [7:0]          code;
    logic [PIX_W:0]      ref_v;
    logic [PIX_W-1:0]    nb [8];

    // Shifted window and the LBP code of the centre it will hold.
    always_comb begin
        lb0_rd = lb0_q[wp_q];
        lb1_rd = lb1_q[wp_q];
        for (int r = 0; r < 3; r++) begin
            win_sh[r][0] = win_q[r][1];
            win_sh[r][1] = win_q[r][2];
        end
        win_sh[0][2] = lb1_rd;
        win_sh[1][2] = lb0_rd;
        win_sh[2][2] = gray_data;
        nb[0] = win_sh[0][0];
        nb[1] = win_sh[0][1];
        nb[2] = win_sh[0][2];
        nb[3] = win_sh[1][0];
        nb[4] = win_sh[1][2];
        nb[5] = win_sh[2][0];
        nb[6] = win_sh[2][1];
        nb[7] = win_sh[2][2];
        // Widened by one bit so centre+THRESH never wraps; an overflowing
        // reference simply yields 0 bits.
        ref_v = {1'b0, win_sh[1][1]} + THR;
        code  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            code[i] = ({1'b0, nb[i]} >= ref_v);
        end
        interior = (o_row_q != '0) && (o_row_q != ROW_LAST) &&
                   (o_col_q != '0) && (o_col_q != COL_LAST);
    end

    // Sequencing FSM, window/line-buffer advance and output slot generation.
    always_comb begin
        state_d     = state_q;
        gray_req_d  = gray_req_q;
        gray_addr_d = gray_addr_q;
        cyc_d       = cyc_q;
        wp_d        = wp_q;
        o_col_d     = o_col_q;
        o_row_d     = o_row_q;
        o_idx_d     = o_idx_q;
        lbp_valid_d = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;
        finish_d    = finish_q;
        shift_en    = 1'b0;
        win_d       = win_q;

        case (state_q)
            IDLE: begin
                if (gray_ready) begin
                    state_d     = READ;
                    gray_req_d  = 1'b1;
                    gray_addr_d = '0;
                    cyc_d       = '0;
                    o_col_d     = '0;
                    o_row_d     = '0;
                    o_idx_d     = '0;
                end
            end
            READ: begin
                cyc_d    = cyc_q + CW'(1);
                // Cycle 0 only issues address 0; its data arrives next cycle.
                shift_en = (cyc_q != '0);
                if (gray_addr_q == ADDR_LAST) begin
                    state_d    = DRAIN;
                    gray_req_d = 1'b0;
                end else begin
                    gray_addr_d = gray_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                cyc_d = cyc_q + CW'(1);
                if (cyc_q == FRAME_END) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end else begin
                    // Samples here are beyond the image; they only feed border slots.
                    shift_en = 1'b1;
                end
            end
            default: ;
        endcase

        if (shift_en) begin
            win_d = win_sh;
            wp_d  = (wp_q == COL_LAST) ? '0 : wp_q + COL_W'(1);
            if (cyc_q >= EMIT_FIRST) begin
`ifdef LBP_BORDER_ZERO_EN
                lbp_valid_d = 1'b1;
                lbp_addr_d  = o_idx_q;
                lbp_data_d  = interior ? code : 8'h00;
`else
                if (interior) begin
                    lbp_valid_d = 1'b1;
                    lbp_addr_d  = o_idx_q;
                    lbp_data_d  = code;
                end
`endif
                o_idx_d = o_idx_q + ADDR_W'(1);
                if (o_col_q == COL_LAST) begin
                    o_col_d = '0;
                    o_row_d = o_row_q + ROW_W'(1);
                end else begin
                    o_col_d = o_col_q + COL_W'(1);
                end
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gray_req_q  <= 1'b0;
            gray_addr_q <= '0;
            cyc_q       <= '0;
            wp_q        <= '0;
            o_col_q     <= '0;
            o_row_q     <= '0;
            o_idx_q     <= '0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            finish_q    <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            gray_req_q  <= gray_req_d;
            gray_addr_q <= gray_addr_d;
            cyc_q       <= cyc_d;
            wp_q        <= wp_d;
            o_col_q     <= o_col_d;
            o_row_q     <= o_row_d;
            o_idx_q     <= o_idx_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            finish_q    <= finish_d;
            win_q       <= win_d;
        end
    end

    // Line buffers as circular delay lines of IMG_W pixels; contents need no reset.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            lb0_q[wp_q] <= gray_data;
            lb1_q[wp_q] <= lb0_rd;
        end
    end

    assign gray_req  = gray_req_q;
    assign gray_addr = gray_addr_q;
    assign lbp_valid = lbp_valid_q;
    assign lbp_addr  = lbp_addr_q;
    assign lbp_data  = lbp_data_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_stream.sv
// Directed bench for lbp_stream on an 8x6 image: one instance with THRESH=0
// and one with THRESH=1, both fed from the same image memory.
module tb_lbp_stream;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int AW = 6;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          gray_ready;
    logic [PW-1:0] gray_data;

    logic          u0_req, u0_valid, u0_fin;
    logic [AW-1:0] u0_addr, u0_laddr;
    logic [7:0]    u0_ldata;
    logic          u1_req, u1_valid, u1_fin;
    logic [AW-1:0] u1_addr, u1_laddr;
    logic [7:0]    u1_ldata;

    logic [7:0] img  [64];
    logic [7:0] exp0 [N];
    logic [7:0] exp1 [N];

    int wa0[$], wd0[$], wt0[$];
    int wa1[$], wd1[$], wt1[$];

    int n_vec = 0;
    int n_err = 0;

    lbp_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .THRESH(0)) u0 (
        .clk(clk), .reset(reset), .gray_ready(gray_ready),
        .gray_req(u0_req), .gray_addr(u0_addr), .gray_data(gray_data),
        .lbp_valid(u0_valid), .lbp_addr(u0_laddr), .lbp_data(u0_ldata),
        .finish(u0_fin)
    );

    lbp_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .THRESH(1)) u1 (
        .clk(clk), .reset(reset), .gray_ready(gray_ready),
        .gray_req(u1_req), .gray_addr(u1_addr), .gray_data(gray_data),
        .lbp_valid(u1_valid), .lbp_addr(u1_laddr), .lbp_data(u1_ldata),
        .finish(u1_fin)
    );

    always #5 clk = ~clk;

    // One-cycle-latency image memory.
    always @(posedge clk) gray_data <= img[u0_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_int(input int a);
        int r, c;
        r = a / W;
        c = a % W;
        return (r >= 1) && (r <= H - 2) && (c >= 1) && (c <= W - 2);
    endfunction

    // Image pattern and hand-derived expected codes for both thresholds.
    task automatic set_frame(input int kind);
        int r, c;
        for (int a = 0; a < 64; a++) img[a] = 8'h00;
        for (int a = 0; a < N; a++) begin
            r = a / W;
            c = a % W;
            case (kind)
                0: begin img[a] = 8'h55;     exp0[a] = 8'hFF; exp1[a] = 8'h00; end
                1: begin img[a] = 8'(c);     exp0[a] = 8'hD6; exp1[a] = 8'h94; end
                2: begin img[a] = 8'd100;    exp0[a] = 8'hFF; exp1[a] = 8'h00; end
                default: begin img[a] = 8'hFF; exp0[a] = 8'hFF; exp1[a] = 8'h00; end
            endcase
        end
        if (kind == 2) begin
            img[2*W+3]  = 8'd0;
            exp0[2*W+3] = 8'hFF;  exp1[2*W+3] = 8'hFF;
            exp0[1*W+2] = 8'h7F;
            exp0[1*W+3] = 8'hBF;
            exp0[1*W+4] = 8'hDF;
            exp0[2*W+2] = 8'hEF;
            exp0[2*W+4] = 8'hF7;
            exp0[3*W+2] = 8'hFB;
            exp0[3*W+3] = 8'hFD;
            exp0[3*W+4] = 8'hFE;
        end
        for (int a = 0; a < N; a++) begin
            if (!is_int(a)) begin
                exp0[a] = 8'h00;
                exp1[a] = 8'h00;
            end
        end
    endtask

    task automatic check_writes(input string tag, input int wa[$], input int wd[$],
                                input int wt[$], input logic [7:0] e[N]);
        int k;
        k = 0;
        for (int a = 0; a < N; a++) begin
`ifndef LBP_BORDER_ZERO_EN
            if (!is_int(a)) continue;
`endif
            if (k < wa.size()) begin
                chk($sformatf("%s_addr%0d", tag, k), wa[k], a);
                chk($sformatf("%s_data%0d", tag, k), wd[k], e[a]);
                chk($sformatf("%s_time%0d", tag, k), wt[k], a + W + 3);
            end
            k++;
        end
        chk($sformatf("%s_count", tag), wa.size(), k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_frame(input string tag);
        int t, t_fin;
        wa0.delete(); wd0.delete(); wt0.delete();
        wa1.delete(); wd1.delete(); wt1.delete();
        do_reset();
        gray_ready = 1'b1;
        @(negedge clk);
        gray_ready = 1'b0;
        t     = 0;
        t_fin = -1;
        while (t < 200 && t_fin < 0) begin
            chk($sformatf("%s_req_t%0d", tag, t), u0_req, (t < N) ? 1 : 0);
            chk($sformatf("%s_gaddr_t%0d", tag, t), u0_addr, (t < N) ? t : N - 1);
            if (u0_valid) begin wa0.push_back(u0_laddr); wd0.push_back(u0_ldata); wt0.push_back(t); end
            if (u1_valid) begin wa1.push_back(u1_laddr); wd1.push_back(u1_ldata); wt1.push_back(t); end
            if (u0_fin) begin
                t_fin = t;
                chk({tag, "_fin1"}, u1_fin, 1);
            end else begin
                @(negedge clk);
                t++;
            end
        end
        chk({tag, "_finish_time"}, t_fin, N + W + 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("%s_sticky%0d", tag, i), {u0_fin, u0_valid, u0_req, u1_fin, u1_valid},
                5'b10010);
        end
        check_writes({tag, "_t0"}, wa0, wd0, wt0, exp0);
        check_writes({tag, "_t1"}, wa1, wd1, wt1, exp1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        gray_ready = 1'b0;
        for (int a = 0; a < 64; a++) img[a] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs", {u0_req, u0_addr, u0_valid, u0_laddr, u0_ldata, u0_fin}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", {u0_req, u0_addr, u0_valid, u0_laddr, u0_ldata, u0_fin}, 0);

        // reset beats gray_ready on the same edge
        reset = 1'b1; gray_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; gray_ready = 1'b0;
        chk("rst_wins_req", u0_req, 0);
        @(negedge clk);
        chk("rst_wins_idle", u0_req, 0);

        set_frame(0); run_frame("const55");
        set_frame(1); run_frame("ramp");
        set_frame(2); run_frame("dip");
        set_frame(3); run_frame("constFF");

        // reset in the middle of READ, then a clean rerun
        set_frame(1);
        do_reset();
        gray_ready = 1'b1;
        @(negedge clk);
        gray_ready = 1'b0;
        for (int i = 0; i < 100 && u0_addr != AW'(30); i++) @(negedge clk);
        chk("mid_addr_reached", u0_addr, 30);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_u0", {u0_req, u0_addr, u0_valid, u0_laddr, u0_ldata, u0_fin}, 0);
        chk("mid_rst_u1", {u1_req, u1_addr, u1_valid, u1_laddr, u1_ldata, u1_fin}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_idle", u0_req, 0);
        run_frame("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
